// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU function codes, CCR bit positions and branch
// condition selects used by the ALU and its result stage.
package cpu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD = 4'h0,
        ALU_ADC = 4'h1,
        ALU_SUB = 4'h2,
        ALU_SBC = 4'h3,
        ALU_AND = 4'h4,
        ALU_OR  = 4'h5,
        ALU_XOR = 4'h6,
        ALU_NOT = 4'h7,
        ALU_SHL = 4'h8,
        ALU_SHR = 4'h9,
        ALU_SAR = 4'hA,
        ALU_ROL = 4'hB,
        ALU_ROR = 4'hC,
        ALU_MOV = 4'hD,
        ALU_CMP = 4'hE,
        ALU_TST = 4'hF
    } alu_op_e;

    localparam int CCR_C = 3;
    localparam int CCR_Z = 2;
    localparam int CCR_N = 1;
    localparam int CCR_V = 0;

    localparam logic [3:0] COND_AL  = 4'd0;
    localparam logic [3:0] COND_NV  = 4'd1;
    localparam logic [3:0] COND_EQ  = 4'd2;
    localparam logic [3:0] COND_NE  = 4'd3;
    localparam logic [3:0] COND_LTU = 4'd4;
    localparam logic [3:0] COND_GEU = 4'd5;
    localparam logic [3:0] COND_GTU = 4'd6;
    localparam logic [3:0] COND_LEU = 4'd7;
    localparam logic [3:0] COND_LT  = 4'd8;
    localparam logic [3:0] COND_GE  = 4'd9;
    localparam logic [3:0] COND_GT  = 4'd10;
    localparam logic [3:0] COND_LE  = 4'd11;
    localparam logic [3:0] COND_MI  = 4'd12;
    localparam logic [3:0] COND_PL  = 4'd13;
    localparam logic [3:0] COND_VS  = 4'd14;
    localparam logic [3:0] COND_VC  = 4'd15;

endpackage

// File: rtl/skid_buffer2.sv
// Two-entry valid/ready buffer with a registered ready; the head entry drives
// the outputs directly so accepted data appears one edge after the push.
module skid_buffer2 #(
    parameter int W = 36
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] in_data_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] out_data_o
);

    logic [1:0]   count;
    logic [1:0]   count_next;
    logic [W-1:0] head;
    logic [W-1:0] tail;
    logic         push;
    logic         pop;

    assign out_valid_o = (count != 2'd0);
    assign out_data_o  = head;
    assign push        = in_valid_i & in_ready_o;
    assign pop         = out_valid_o & out_ready_i;

    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + 2'd1;
        end else if (!push && pop) begin
            count_next = count - 2'd1;
        end
    end

    // A push lands in the head slot whenever the head is (or is becoming) free;
    // ready only drops at two entries, so a push never meets a full buffer.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            count      <= 2'd0;
            in_ready_o <= 1'b1;
            head       <= '0;
            tail       <= '0;
        end else begin
            count      <= count_next;
            in_ready_o <= (count_next != 2'd2);
            if (pop && count == 2'd2) begin
                head <= tail;
            end
            if (push) begin
                if (count == 2'd0 || (count == 2'd1 && pop)) begin
                    head <= in_data_i;
                end else begin
                    tail <= in_data_i;
                end
            end
        end
    end

endmodule

// File: rtl/alu_result_stage.sv
// ALU result stage: buffers results and flags toward writeback, owns the
// condition-code register and evaluates branch conditions from it.
module alu_result_stage
    import cpu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] alu_out_i,
    input  logic             alu_c_i,
    input  logic             alu_z_i,
    input  logic             alu_n_i,
    input  logic             alu_v_i,
    input  logic             flag_we_i,
    input  logic             chain_i,
    output logic             alu_c_in_o,
    output logic             alu_z_in_o,
    input  logic             ccr_load_i,
    input  logic [3:0]       ccr_data_i,
    output logic [3:0]       ccr_o,
    input  logic [3:0]       cond_i,
    output logic             cond_true_o,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o,
    output logic [3:0]       out_flags_o
);

    logic [3:0]       ccr;
    logic [3:0]       alu_flags;
    logic             accept;
    logic [WIDTH+3:0] buf_out;

    assign alu_flags = {alu_c_i, alu_z_i, alu_n_i, alu_v_i};
    assign accept    = in_valid_i & in_ready_o;

    skid_buffer2 #(
        .W(WIDTH + 4)
    ) u_skid (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .in_valid_i (in_valid_i),
        .in_ready_o (in_ready_o),
        .in_data_i  ({alu_out_i, alu_flags}),
        .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i),
        .out_data_o (buf_out)
    );

    assign out_data_o  = buf_out[WIDTH+3:4];
    assign out_flags_o = buf_out[3:0];

    // Flags commit at accept time, not at writeback, so backpressure never delays them.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ccr <= 4'b0000;
        end else if (ccr_load_i) begin
            ccr <= ccr_data_i;
        end else if (accept && flag_we_i) begin
            ccr <= alu_flags;
        end
    end

    assign ccr_o      = ccr;
    assign alu_c_in_o = chain_i & ccr[CCR_C];
    assign alu_z_in_o = chain_i & ~ccr[CCR_Z];

    always_comb begin
        cond_true_o = 1'b0;
        case (cond_i)
            COND_AL:  cond_true_o = 1'b1;
            COND_NV:  cond_true_o = 1'b0;
            COND_EQ:  cond_true_o = ccr[CCR_Z];
            COND_NE:  cond_true_o = ~ccr[CCR_Z];
            COND_LTU: cond_true_o = ccr[CCR_C];
            COND_GEU: cond_true_o = ~ccr[CCR_C];
            COND_GTU: cond_true_o = ~ccr[CCR_C] & ~ccr[CCR_Z];
            COND_LEU: cond_true_o = ccr[CCR_C] | ccr[CCR_Z];
            COND_LT:  cond_true_o = ccr[CCR_N] ^ ccr[CCR_V];
            COND_GE:  cond_true_o = ~(ccr[CCR_N] ^ ccr[CCR_V]);
            COND_GT:  cond_true_o = ~ccr[CCR_Z] & ~(ccr[CCR_N] ^ ccr[CCR_V]);
            COND_LE:  cond_true_o = ccr[CCR_Z] | (ccr[CCR_N] ^ ccr[CCR_V]);
            COND_MI:  cond_true_o = ccr[CCR_N];
            COND_PL:  cond_true_o = ~ccr[CCR_N];
            COND_VS:  cond_true_o = ccr[CCR_V];
            COND_VC:  cond_true_o = ~ccr[CCR_V];
            default:  cond_true_o = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_alu_result_stage.sv
// Self-checking bench for alu_result_stage: directed scenarios plus random
// traffic compared against a queue-based model of the buffer and CCR.
module tb_alu_result_stage;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [31:0] alu_out_i;
    logic        alu_c_i, alu_z_i, alu_n_i, alu_v_i;
    logic        flag_we_i;
    logic        chain_i;
    logic        alu_c_in_o, alu_z_in_o;
    logic        ccr_load_i;
    logic [3:0]  ccr_data_i;
    logic [3:0]  ccr_o;
    logic [3:0]  cond_i;
    logic        cond_true_o;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] out_data_o;
    logic [3:0]  out_flags_o;

    int testCount = 0;
    int failCount = 0;

    logic [35:0] modelQ[$];
    logic [3:0]  ccrModel;
    logic [31:0] popLog[$];
    logic        lastAccepted;

    always #5 clk_i = ~clk_i;

    alu_result_stage #(.WIDTH(32)) dut (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .in_valid_i (in_valid_i),
        .in_ready_o (in_ready_o),
        .alu_out_i  (alu_out_i),
        .alu_c_i    (alu_c_i),
        .alu_z_i    (alu_z_i),
        .alu_n_i    (alu_n_i),
        .alu_v_i    (alu_v_i),
        .flag_we_i  (flag_we_i),
        .chain_i    (chain_i),
        .alu_c_in_o (alu_c_in_o),
        .alu_z_in_o (alu_z_in_o),
        .ccr_load_i (ccr_load_i),
        .ccr_data_i (ccr_data_i),
        .ccr_o      (ccr_o),
        .cond_i     (cond_i),
        .cond_true_o(cond_true_o),
        .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i),
        .out_data_o (out_data_o),
        .out_flags_o(out_flags_o)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        testCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Branch truth table written in terms of named flags {C,Z,N,V}.
    function automatic logic condModel(input logic [3:0] f, input logic [3:0] sel);
        logic c, z, n, v;
        {c, z, n, v} = f;
        case (sel)
            4'd0:  return 1'b1;
            4'd1:  return 1'b0;
            4'd2:  return z;
            4'd3:  return !z;
            4'd4:  return c;
            4'd5:  return !c;
            4'd6:  return !c && !z;
            4'd7:  return c || z;
            4'd8:  return n != v;
            4'd9:  return n == v;
            4'd10: return !z && (n == v);
            4'd11: return z || (n != v);
            4'd12: return n;
            4'd13: return !n;
            4'd14: return v;
            default: return !v;
        endcase
    endfunction

    task automatic applyStimulus(input logic inValid, input logic [31:0] data, input logic [3:0] flags,
                                 input logic flagWe, input logic chain, input logic ccrLoad,
                                 input logic [3:0] ccrData, input logic [3:0] cond, input logic outReady);
        logic acc, pop;
        @(negedge clk_i);
        in_valid_i = inValid;
        alu_out_i  = data;
        {alu_c_i, alu_z_i, alu_n_i, alu_v_i} = flags;
        flag_we_i  = flagWe;
        chain_i    = chain;
        ccr_load_i = ccrLoad;
        ccr_data_i = ccrData;
        cond_i     = cond;
        out_ready_i = outReady;
        #1;
        checkOutput("cond_true", cond_true_o, condModel(ccrModel, cond));
        checkOutput("c_in", alu_c_in_o, chain & ccrModel[3]);
        checkOutput("z_in", alu_z_in_o, chain & ~ccrModel[2]);
        acc = inValid && (modelQ.size() < 2);
        pop = (modelQ.size() > 0) && outReady;
        if (pop) begin
            popLog.push_back(out_data_o);
            void'(modelQ.pop_front());
        end
        if (acc) modelQ.push_back({data, flags});
        if (ccrLoad) ccrModel = ccrData;
        else if (acc && flagWe) ccrModel = flags;
        lastAccepted = acc;
        @(posedge clk_i);
        #1;
        checkOutput("in_ready", in_ready_o, modelQ.size() < 2);
        checkOutput("out_valid", out_valid_o, modelQ.size() > 0);
        if (modelQ.size() > 0) begin
            checkOutput("out_data", out_data_o, modelQ[0][35:4]);
            checkOutput("out_flags", out_flags_o, modelQ[0][3:0]);
        end
        checkOutput("ccr", ccr_o, ccrModel);
    endtask

    task automatic idle(input logic outReady);
        applyStimulus(1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 4'($urandom_range(0, 15)), outReady);
    endtask

    initial begin
        logic [31:0] valA, valB, valC;
        int tries;

        rst_n_i = 1'b0;
        in_valid_i = 1'b0; alu_out_i = '0;
        {alu_c_i, alu_z_i, alu_n_i, alu_v_i} = 4'h0;
        flag_we_i = 1'b0; chain_i = 1'b0; ccr_load_i = 1'b0; ccr_data_i = 4'h0;
        cond_i = 4'd0; out_ready_i = 1'b0;
        ccrModel = 4'h0;
        lastAccepted = 1'b0;

        #8;
        checkOutput("rst_in_ready", in_ready_o, 1'b1);
        checkOutput("rst_out_valid", out_valid_o, 1'b0);
        checkOutput("rst_out_data", out_data_o, 32'h0);
        checkOutput("rst_out_flags", out_flags_o, 4'h0);
        checkOutput("rst_ccr", ccr_o, 4'h0);
        #4 rst_n_i = 1'b1;

        applyStimulus(1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 4'd0, 1'b1);
        checkOutput("idle_cond_al", cond_true_o, 1'b1);
        applyStimulus(1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 4'd1, 1'b1);
        checkOutput("idle_cond_nv", cond_true_o, 1'b0);

        // Zero result with Z set.
        applyStimulus(1'b1, 32'h0, 4'b0100, 1'b1, 1'b0, 1'b0, 4'h0, 4'd0, 1'b1);
        checkOutput("zero_data", out_data_o, 32'h0);
        checkOutput("zero_flags", out_flags_o, 4'b0100);
        checkOutput("zero_ccr", ccr_o, 4'b0100);
        cond_i = 4'd2; #1 checkOutput("zero_cond_eq", cond_true_o, 1'b1);
        cond_i = 4'd3; #1 checkOutput("zero_cond_ne", cond_true_o, 1'b0);
        idle(1'b1);

        // Backpressure: A and B fill the buffer, C is held by the source.
        valA = 32'hAAAA_0001; valB = 32'hBBBB_0002; valC = 32'hCCCC_0003;
        popLog.delete();
        applyStimulus(1'b1, valA, 4'h1, 1'b0, 1'b0, 1'b0, 4'h0, 4'd0, 1'b0);
        applyStimulus(1'b1, valB, 4'h2, 1'b0, 1'b0, 1'b0, 4'h0, 4'd0, 1'b0);
        checkOutput("full_in_ready", in_ready_o, 1'b0);
        applyStimulus(1'b1, valC, 4'h3, 1'b0, 1'b0, 1'b0, 4'h0, 4'd0, 1'b0);
        checkOutput("hold_head", out_data_o, valA);
        tries = 0;
        do begin
            applyStimulus(1'b1, valC, 4'h3, 1'b0, 1'b0, 1'b0, 4'h0, 4'd0, 1'b1);
            tries++;
        end while (!lastAccepted && tries < 10);
        checkOutput("c_accept_bound", lastAccepted, 1'b1);
        for (int i = 0; i < 4; i++) idle(1'b1);
        checkOutput("order_count", popLog.size(), 3);
        if (popLog.size() == 3) begin
            checkOutput("order_a", popLog[0], valA);
            checkOutput("order_b", popLog[1], valB);
            checkOutput("order_c", popLog[2], valC);
        end

        // Extended-precision chain: low word carries out, Z clear.
        applyStimulus(1'b1, 32'hFFFF_FFFE, 4'b1000, 1'b1, 1'b0, 1'b0, 4'h0, 4'd4, 1'b1);
        chain_i = 1'b1; #1;
        checkOutput("chain_cin", alu_c_in_o, 1'b1);
        checkOutput("chain_zin", alu_z_in_o, 1'b1);
        chain_i = 1'b0; #1;
        checkOutput("nochain_cin", alu_c_in_o, 1'b0);
        checkOutput("nochain_zin", alu_z_in_o, 1'b0);
        applyStimulus(1'b1, 32'h0000_0001, 4'b0000, 1'b1, 1'b1, 1'b0, 4'h0, 4'd6, 1'b1);
        idle(1'b1);

        // Direct load wins over a simultaneous flag update.
        applyStimulus(1'b1, 32'h1234_5678, 4'b1000, 1'b1, 1'b0, 1'b1, 4'b0011, 4'd8, 1'b1);
        checkOutput("load_ccr", ccr_o, 4'b0011);
        cond_i = 4'd8;  #1 checkOutput("load_cond_lt", cond_true_o, 1'b0);
        cond_i = 4'd14; #1 checkOutput("load_cond_vs", cond_true_o, 1'b1);
        idle(1'b1);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'($urandom_range(0, 3) != 0), $urandom, 4'($urandom), 1'($urandom),
                          1'($urandom), 1'($urandom_range(0, 9) == 0), 4'($urandom),
                          4'($urandom), 1'($urandom_range(0, 2) != 0));
        end

        // Asynchronous reset with the buffer full.
        applyStimulus(1'b1, 32'h5555_0001, 4'hF, 1'b1, 1'b0, 1'b0, 4'h0, 4'd0, 1'b0);
        applyStimulus(1'b1, 32'h5555_0002, 4'hE, 1'b1, 1'b0, 1'b0, 4'h0, 4'd0, 1'b0);
        applyStimulus(1'b1, 32'h5555_0003, 4'hD, 1'b1, 1'b0, 1'b0, 4'h0, 4'd0, 1'b0);
        checkOutput("prerst_full", in_ready_o, 1'b0);
        #2 rst_n_i = 1'b0;
        #1;
        checkOutput("arst_out_valid", out_valid_o, 1'b0);
        checkOutput("arst_ccr", ccr_o, 4'h0);
        modelQ.delete();
        ccrModel = 4'h0;
        in_valid_i = 1'b0;
        @(negedge clk_i);
        #2 rst_n_i = 1'b1;
        idle(1'b1);
        checkOutput("postrst_in_ready", in_ready_o, 1'b1);
        checkOutput("postrst_out_valid", out_valid_o, 1'b0);
        for (int i = 0; i < 3; i++) idle(1'b1);
        applyStimulus(1'b1, 32'h0BAD_F00D, 4'h6, 1'b1, 1'b0, 1'b0, 4'h0, 4'd2, 1'b1);
        checkOutput("postrst_fresh", out_data_o, 32'h0BAD_F00D);
        idle(1'b1);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
